tinyalu_responder: RTL and testbench

- Synthesizable ALU responder: the DUT side of the start/done operation handshake that the tester and BFM drive.
- Captures operands A and B and the opcode on a start request.
- Computes add/and/xor in one clock and multiply in a MUL_STAGES-deep pipeline.
- Returns a 16-bit result with a one-cycle done pulse; sits directly behind the BFM pins.

---
 rtl/tinyalu_responder.sv | 159 +++++++++++++++
 tb/tb_tinyalu_responder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tinyalu_responder.sv
// TinyALU responder: start/done handshake, single-cycle add/and/xor, pipelined multiply.
// Optional TINYALU_RESP_ERR_EN: reserved opcodes complete with err pulse and result 16'hDEAD.
module tinyalu_responder #(
  parameter int MUL_STAGES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        done,
  output logic [15:0] result,
  output logic        busy
`ifdef TINYALU_RESP_ERR_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_HOLD} state_t;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_RST = 3'b111;

  state_t      state_q, state_d;
  logic        start_q, start_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] pp_lo_q, pp_lo_d, pp_hi_q, pp_hi_d;
  logic        done_q, done_d;
  logic [15:0] result_q, result_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        accept;

  assign accept = (state_q == S_IDLE) && start && !start_q;

  always_comb begin
    state_d  = state_q;
    start_d  = start;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    pp_lo_d  = pp_lo_q;
    pp_hi_d  = pp_hi_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    result_d = result_q;
    busy_d   = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d  = A;
          b_d  = B;
          op_d = op;
          case (op)
            OP_ADD, OP_AND, OP_XOR: begin
              state_d = S_EXEC;
              busy_d  = 1'b1;
            end
            OP_MUL: begin
              state_d = S_MUL;
              busy_d  = 1'b1;
              cnt_d   = 3'(MUL_STAGES - 1);
            end
            OP_RST: result_d = 16'h0000;
`ifdef TINYALU_RESP_ERR_EN
            3'b101, 3'b110: begin
              state_d = S_EXEC;
              busy_d  = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      S_EXEC: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_HOLD;
        case (op_q)
          OP_ADD:  result_d = {8'h00, a_q} + {8'h00, b_q};
          OP_AND:  result_d = {8'h00, a_q & b_q};
          OP_XOR:  result_d = {8'h00, a_q ^ b_q};
          default: begin
`ifdef TINYALU_RESP_ERR_EN
            result_d = 16'hDEAD;
            err_d    = 1'b1;
`endif
          end
        endcase
      end
      S_MUL: begin
        // Two 8x4 partial products are registered; the final edge sums them.
        pp_lo_d = {4'h0, a_q} * {8'h00, b_q[3:0]};
        pp_hi_d = {4'h0, a_q} * {8'h00, b_q[7:4]};
        if (cnt_q == 3'd0) begin
          result_d = {4'h0, pp_lo_q} + {pp_hi_q, 4'h0};
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_HOLD;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_HOLD: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      pp_lo_q  <= '0;
      pp_hi_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      pp_lo_q  <= pp_lo_d;
      pp_hi_q  <= pp_hi_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
      busy_q   <= busy_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;
  assign busy   = busy_q;
`ifdef TINYALU_RESP_ERR_EN
  assign err    = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_tinyalu_responder.sv
// Randomized bench for tinyalu_responder: transaction-level model predicts done/busy/result per cycle.
module tb_tinyalu_responder;
  localparam int MS = 3;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  A, B;
  logic [2:0]  op;
  logic        done, busy;
  logic [15:0] result;
`ifdef TINYALU_RESP_ERR_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  tinyalu_responder #(.MUL_STAGES(MS)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .start(start),
    .done(done), .result(result), .busy(busy)
`ifdef TINYALU_RESP_ERR_EN
    , .err(err)
`endif
  );

  int tests = 0, fails = 0;
  int edge_cnt = 0;
  bit rst_at_edge = 1'b0;
  int acc_edge = -1, done_at = -1;
  logic [15:0] m_result = 16'h0, m_pending = 16'h0;
  bit m_clear = 1'b0, m_err_op = 1'b0;
  bit exp_done, exp_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic int lat_of(input logic [2:0] o);
    case (o)
      3'd1, 3'd2, 3'd3: return 1;
      3'd4:             return MS;
`ifdef TINYALU_RESP_ERR_EN
      3'd5, 3'd6:       return 1;
`endif
      default:          return 0;
    endcase
  endfunction

  function automatic logic [15:0] model_res(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] o);
    int ia = a, ib = b;
    case (o)
      3'd1:    return 16'(ia + ib);
      3'd2:    return 16'(a & b);
      3'd3:    return 16'(a ^ b);
      3'd4:    return 16'(ia * ib);
      default: return 16'hDEAD;
    endcase
  endfunction

  always @(posedge clk) begin
    edge_cnt++;
    rst_at_edge = reset;
  end

  // Per-cycle compare against the transaction model.
  always @(negedge clk) begin
    if (edge_cnt > 0) begin
      if (rst_at_edge) begin
        m_result = 16'h0;
        acc_edge = -1;
        done_at  = -1;
      end else begin
        if (edge_cnt == acc_edge && m_clear) m_result = 16'h0;
        if (edge_cnt == done_at) m_result = m_pending;
      end
      exp_done = !rst_at_edge && done_at >= 0 && edge_cnt == done_at;
      exp_busy = !rst_at_edge && done_at >= 0 && edge_cnt >= acc_edge && edge_cnt < done_at;
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("result", 32'(result), 32'(m_result));
`ifdef TINYALU_RESP_ERR_EN
      chk("err", 32'(err), 32'(exp_done && m_err_op));
`endif
    end
  end

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                       input bit mid_change);
    int lat = lat_of(o);
    @(negedge clk);
    A = a; B = b; op = o; start = 1'b1;
    acc_edge  = edge_cnt + 1;
    m_clear   = (o == 3'd7);
    m_err_op  = (o == 3'd5 || o == 3'd6);
    m_pending = model_res(a, b, o);
    done_at   = (lat > 0) ? acc_edge + lat : -1;
    @(negedge clk);
    if (mid_change) begin
      A = 8'($urandom); B = 8'($urandom); op = 3'($urandom);
    end
    repeat (lat + $urandom_range(0, 2)) @(negedge clk);
    start = 1'b0;
    repeat (1 + $urandom_range(0, 1)) @(negedge clk);
  endtask

  function automatic logic [7:0] rdata();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; A = '0; B = '0; op = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    do_op(8'hFF, 8'hFF, 3'd1, 1'b0);
    chk("lit_add", 32'(result), 32'h01FE);
    chk("lit_add_model", 32'(m_result), 32'h01FE);

    do_op(8'hFF, 8'hFF, 3'd4, 1'b1);
    chk("lit_mul", 32'(result), 32'hFE01);
    chk("lit_mul_model", 32'(m_result), 32'hFE01);

    do_op(8'hA5, 8'h0F, 3'd2, 1'b0);
    chk("lit_and", 32'(result), 32'h0005);
    do_op(8'hA5, 8'h0F, 3'd3, 1'b0);
    chk("lit_xor", 32'(result), 32'h00AA);
    chk("lit_xor_model", 32'(m_result), 32'h00AA);

    do_op(8'hFF, 8'hFF, 3'd1, 1'b0);
    do_op(8'h12, 8'h34, 3'd0, 1'b0);
    chk("lit_noop_keep", 32'(result), 32'h01FE);
    do_op(8'h12, 8'h34, 3'd7, 1'b0);
    chk("lit_soft_clear", 32'(result), 32'h0000);

    // Reset one clock after a multiply is accepted.
    do_op(8'hFF, 8'h02, 3'd1, 1'b0);
    @(negedge clk);
    A = 8'h10; B = 8'h10; op = 3'd4; start = 1'b1;
    acc_edge = edge_cnt + 1; m_clear = 1'b0; m_err_op = 1'b0;
    m_pending = 16'h0100; done_at = acc_edge + MS;
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (MS + 2) @(negedge clk);
    chk("lit_rst_mid_result", 32'(result), 32'h0000);
    chk("lit_rst_mid_busy", 32'(busy), 32'h0);

    do_op(8'h01, 8'h02, 3'd1, 1'b0);
    chk("lit_add_after_rst", 32'(result), 32'h0003);

`ifdef TINYALU_RESP_ERR_EN
    do_op(8'h01, 8'h02, 3'd5, 1'b0);
    chk("lit_err_dead", 32'(result), 32'hDEAD);
`endif

    for (int i = 0; i < 1000; i++)
      do_op(rdata(), rdata(), 3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
